// File: rtl/matrix_repeat_fifo.sv
// matrix_repeat_fifo
//   Buffers DIM0 x DIM1 matrices and presents each head matrix a per-entry
//   number of times (replays) before retiring it, so a matmul operand can be
//   reused without re-fetching it from memory.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   in_data        : input matrix, element index = row*DIM0+col
//   in_repeat      : presentations for this entry (0 behaves as 1)
//   in_valid       : input matrix valid
//   in_ready       : FIFO can accept (not full; independent of out_ready)
//   out_data       : head matrix, same element order as in_data
//   out_valid      : head matrix valid (not empty)
//   out_ready      : consumer accepts the current presentation
//   out_rep_idx    : 0-based replay index of the current presentation
//   out_last       : current presentation is the final replay of the head
//   count          : stored entries, head included
//   empty/full     : count==0 / count==FIFO_SIZE
//   almost_full    : count>=ALMOST_FULL_THRESH
module matrix_repeat_fifo #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned DIM0               = 4,
  parameter int unsigned DIM1               = 4,
  parameter int unsigned FIFO_SIZE          = 8,
  parameter int unsigned REPEAT_WIDTH       = 4,
  parameter int unsigned ALMOST_FULL_THRESH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data [DIM0*DIM1],
  input  logic [REPEAT_WIDTH-1:0]       in_repeat,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data [DIM0*DIM1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [REPEAT_WIDTH-1:0]       out_rep_idx,
  output logic                          out_last,
  output logic [$clog2(FIFO_SIZE):0]    count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full
);

  localparam int unsigned NUM_ELEM = DIM0 * DIM1;
  localparam int unsigned FLAT_W   = NUM_ELEM * DATA_WIDTH;
  localparam int unsigned PTR_W    = $clog2(FIFO_SIZE);
  localparam int unsigned CNT_W    = PTR_W + 1;

  // Entry storage: flattened matrix plus its effective repeat value
  logic [FLAT_W-1:0]       data_mem_q [FIFO_SIZE];
  logic [REPEAT_WIDTH-1:0] rep_mem_q  [FIFO_SIZE];

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [REPEAT_WIDTH-1:0] rep_cnt_q, rep_cnt_d;
  logic                    empty_q, empty_d;
  logic                    full_q, full_d;
  logic                    almost_full_q, almost_full_d;

  logic [FLAT_W-1:0]       in_flat;
  logic [FLAT_W-1:0]       head_flat;
  logic [REPEAT_WIDTH-1:0] head_rep;
  logic [REPEAT_WIDTH-1:0] in_rep_eff;
  logic                    push;
  logic                    handshake;
  logic                    pop;
  logic                    replay;

  // Matrix flatten / unflatten is pure wiring
  for (genvar g = 0; g < NUM_ELEM; g++) begin : g_flat
    assign in_flat[g*DATA_WIDTH +: DATA_WIDTH] = in_data[g];
    assign out_data[g] = head_flat[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign head_flat  = data_mem_q[rd_ptr_q];
  assign head_rep   = rep_mem_q[rd_ptr_q];
  assign in_rep_eff = (in_repeat == '0) ? REPEAT_WIDTH'(1) : in_repeat;

  // Handshake qualifiers; all flow control comes from registered state
  assign in_ready  = !full_q;
  assign out_valid = !empty_q;
  // Stored repeat is never 0, so head_rep-1 cannot underflow; gating with
  // out_valid keeps out_last low on stale storage when empty
  assign out_last  = out_valid && (rep_cnt_q == (head_rep - REPEAT_WIDTH'(1)));
  assign push      = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && out_last;
  assign replay    = handshake && !out_last;

  assign out_rep_idx = rep_cnt_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;

  // Next-state for pointers, replay counter, occupancy and status flags
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rep_cnt_d     = rep_cnt_q;
    count_d       = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rep_cnt_d = '0;
    end else if (replay) begin
      rep_cnt_d = rep_cnt_q + REPEAT_WIDTH'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    empty_d       = (count_d == '0);
    full_d        = (32'(count_d) == FIFO_SIZE);
    almost_full_d = (32'(count_d) >= ALMOST_FULL_THRESH);
  end

  // Control state; reset drops all entries and any partial replay
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rep_cnt_q     <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rep_cnt_q     <= rep_cnt_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
    end
  end

  // Entry storage write; contents are don't-care after reset since the
  // pointers and count are cleared, and a write during reset is never read
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= in_flat;
      rep_mem_q[wr_ptr_q]  <= in_rep_eff;
    end
  end

endmodule

// File: tb/tb_matrix_repeat_fifo.sv
module tb_matrix_repeat_fifo;

  localparam int unsigned DW  = 8;
  localparam int unsigned D0  = 4;
  localparam int unsigned D1  = 4;
  localparam int unsigned N   = D0 * D1;
  localparam int unsigned FS  = 8;
  localparam int unsigned RW  = 4;
  localparam int unsigned AFT = 6;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data [N];
  logic [RW-1:0] in_repeat;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data [N];
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_rep_idx;
  logic          out_last;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;

  matrix_repeat_fifo #(
    .DATA_WIDTH(DW), .DIM0(D0), .DIM1(D1), .FIFO_SIZE(FS),
    .REPEAT_WIDTH(RW), .ALMOST_FULL_THRESH(AFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_repeat(in_repeat), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_rep_idx(out_rep_idx), .out_last(out_last),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int seed;
    int idx;
    bit last;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  int hs_count = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected replays for one accepted push; repeat 0 behaves as 1
  task automatic sb_push(input int seed, input int rep);
    int eff;
    eff = (rep == 0) ? 1 : rep;
    for (int k = 0; k < eff; k++) sb_q.push_back('{seed, k, (k == eff - 1)});
  endtask

  // Monitor: scoreboard pop on every handshake, plus stall-stability check
  logic [DW-1:0] prev_data [N];
  bit            prev_stall = 1'b0;
  int            prev_idx   = 0;

  always @(negedge clk) begin
    exp_t e;
    int   bad;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        bad = 0;
        for (int i = 0; i < N; i++) if (out_data[i] !== prev_data[i]) bad++;
        check("stall_data_changed_elems", bad, 0);
        check("stall_rep_idx", int'(out_rep_idx), prev_idx);
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got handshake idx %0d expected none at %0t",
                   out_rep_idx, $time);
        end else begin
          e   = sb_q.pop_front();
          bad = 0;
          for (int i = 0; i < N; i++) if (out_data[i] !== 8'(e.seed * N + i)) bad++;
          check($sformatf("out_data_bad_elems(seed %0d)", e.seed), bad, 0);
          check($sformatf("out_rep_idx(seed %0d)", e.seed), int'(out_rep_idx), e.idx);
          check($sformatf("out_last(seed %0d)", e.seed), int'(out_last), int'(e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = int'(out_rep_idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mat(input int seed);
    for (int i = 0; i < N; i++) in_data[i] = 8'(seed * N + i);
  endtask

  // One-cycle push attempt; expectation queued only if acceptance is expected
  task automatic push_one(input int seed, input int rep, input bit exp_acc);
    set_mat(seed);
    in_repeat = 4'(rep);
    in_valid  = 1'b1;
    check($sformatf("in_ready(push seed %0d)", seed), int'(in_ready), int'(exp_acc));
    if (exp_acc) sb_push(seed, rep);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag, input int cnt);
    check({tag, "_count"},       int'(count),       cnt);
    check({tag, "_empty"},       int'(empty),       int'(cnt == 0));
    check({tag, "_full"},        int'(full),        int'(cnt == FS));
    check({tag, "_almost_full"}, int'(almost_full), int'(cnt >= AFT));
    check({tag, "_out_valid"},   int'(out_valid),   int'(cnt != 0));
    check({tag, "_in_ready"},    int'(in_ready),    int'(cnt != FS));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_repeat = '0;
    out_ready = 1'b0;
    set_mat(0);

    // Reset state
    tick();
    tick();
    check_status("reset", 0);
    check("reset_rep_idx", int'(out_rep_idx), 0);
    check("reset_last", int'(out_last), 0);
    rst = 1'b0;

    // Matrix A, repeat 3, consumer always ready
    out_ready = 1'b1;
    push_one(0, 3, 1'b1);
    check_status("A_pushed", 1);
    check("A_idx0", int'(out_rep_idx), 0);
    check("A_last0", int'(out_last), 0);
    tick();
    check("A_idx1", int'(out_rep_idx), 1);
    check("A_count1", int'(count), 1);
    tick();
    check("A_idx2", int'(out_rep_idx), 2);
    check("A_last2", int'(out_last), 1);
    tick();
    check_status("A_done", 0);

    // Matrix B, repeat 0 -> single presentation
    push_one(1, 0, 1'b1);
    check("B_idx", int'(out_rep_idx), 0);
    check("B_last", int'(out_last), 1);
    tick();
    check_status("B_done", 0);

    // Fill to full with no consumer, then a rejected ninth push
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_one(2 + i, 1, 1'b1);
      check_status($sformatf("fill%0d", i + 1), i + 1);
    end
    push_one(10, 1, 1'b0);
    check_status("reject", 8);

    // Full + final-replay pop: no push that cycle, push next cycle
    set_mat(11);
    in_repeat = 4'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("fullpop_in_ready", int'(in_ready), 0);
    tick();
    out_ready = 1'b0;
    check_status("after_pop", 7);
    sb_push(11, 1);
    tick();
    in_valid = 1'b0;
    check_status("refill", 8);

    // Drain in order
    out_ready = 1'b1;
    repeat (8) tick();
    check_status("drained", 0);
    check("drained_sb_left", sb_q.size(), 0);

    // Random backpressure, four entries of repeat 2
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(12 + i, 2, 1'b1);
    check_status("bp_loaded", 4);
    hs0 = hs_count;
    for (int cyc = 0; cyc < 400 && sb_q.size() > 0; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b0;
    check("bp_handshakes", hs_count - hs0, 8);
    check_status("bp_done", 0);

    // Reset in the middle of a replay
    for (int i = 0; i < 3; i++) push_one(16 + i, 3, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mid_rep_idx", int'(out_rep_idx), 1);
    check("mid_count", int'(count), 3);
    rst      = 1'b1;
    in_valid = 1'b1;
    set_mat(20);
    sb_q.delete();
    tick();
    check_status("post_rst", 0);
    check("post_rst_rep_idx", int'(out_rep_idx), 0);
    check("post_rst_last", int'(out_last), 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check_status("post_rst_idle", 0);

    // Fresh push replays from index 0
    out_ready = 1'b1;
    push_one(19, 2, 1'b1);
    check("fresh_idx0", int'(out_rep_idx), 0);
    tick();
    check("fresh_idx1", int'(out_rep_idx), 1);
    tick();
    check_status("final", 0);
    check("final_sb_left", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_repeat_fifo.md
Name: matrix_repeat_fifo

Overview:
- Parametrised successor to the plain matrix FIFO.
- Buffers DIM0 x DIM1 matrices and replays each buffered matrix a per-entry number of times before retiring it, so a matmul operand can be reused without re-fetching.
- Adds occupancy, almost-full and replay-position outputs.
- Sits between operand loaders and matmul / systolic cores.

Parameters:
- DATA_WIDTH, 8, bits per matrix element.
- DIM0, 4, matrix columns.
- DIM1, 4, matrix rows.
- FIFO_SIZE, 8, matrix entries stored; power of two, at least 2.
- REPEAT_WIDTH, 4, width of the per-entry repeat count.
- ALMOST_FULL_THRESH, 6, occupancy at or above which almost_full is asserted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  DATA_WIDTH x [DIM0*DIM1]  unpacked input matrix, element index = row*DIM0+col.
- in_repeat  in  REPEAT_WIDTH  number of times the entry is presented; 0 is treated as 1.
- in_valid  in  1  input matrix valid.
- in_ready  out  1  FIFO can accept.
- out_data  out  DATA_WIDTH x [DIM0*DIM1]  head matrix, same element ordering as in_data.
- out_valid  out  1  head matrix valid.
- out_ready  in  1  consumer accepts.
- out_rep_idx  out  REPEAT_WIDTH  current replay index of the head, 0-based.
- out_last  out  1  current presentation is the final replay of the head.
- count  out  $clog2(FIFO_SIZE)+1  entries stored, including the head.
- empty  out  1  count==0.
- full  out  1  count==FIFO_SIZE.
- almost_full  out  1  count>=ALMOST_FULL_THRESH.

Behaviour:
- Interface decision (fixed): one clock, clk; reset rst is synchronous and active-high.
- Storage: FIFO_SIZE entries, each holding the flattened matrix plus its effective repeat value (max(in_repeat,1)). Write and read pointers wrap modulo FIFO_SIZE. Matrix flatten/unflatten is pure wiring.
- Push: occurs on a cycle where in_valid && in_ready. in_ready = !full and is independent of out_ready; there is no push-through when full.
- Latency: a matrix pushed into an empty FIFO at edge t gives out_valid=1 in the cycle after edge t. There is no same-cycle fall-through.
- Presentation:
  - out_valid = !empty.
  - out_data = head entry, held stable while out_valid && !out_ready.
  - out_last = (rep_cnt == head_repeat-1).
- Replay counter rep_cnt (drives out_rep_idx):
  - On out_valid && out_ready && !out_last: rep_cnt increments, and the head is neither popped nor changed.
  - On out_valid && out_ready && out_last: the head is popped, the read pointer advances and rep_cnt returns to 0.
- count update:
  - Push without pop: +1.
  - Pop without push: -1.
  - Simultaneous push and pop: unchanged.
  - Replay-only handshakes do not change count.
- Full with final-replay pop: in_ready stays 0 in that cycle; space becomes available the following cycle.
- Single-entry FIFO: a push and a final-replay pop in the same cycle leave the new entry as head next cycle, with rep_cnt=0.
- in_repeat is sampled only at push. Changes afterwards do not affect stored entries.
- Reset values:
  - in_ready=1, out_valid=0, out_rep_idx=0, out_last=0.
  - count=0, empty=1, full=0, almost_full=0.
  - Pointers and rep_cnt are 0.
  - out_data content is don't-care.
- Reset mid-operation discards all entries and any partial replay. The reset cycle accepts no push.
- Status outputs (count, empty, full, almost_full) are registered or derived from registered state only; no combinational path from in_valid or out_ready.

Test Plan:
- Reset, then push matrix A (elements 0..15) with in_repeat=3, out_ready=1 → out_valid asserted the cycle after the push edge, then three consecutive handshakes with out_rep_idx 0,1,2 and out_last on the third only; count goes 1→0 after the third; empty=1.
- in_repeat=0 on matrix B → exactly one presentation with out_rep_idx=0 and out_last=1.
- out_ready=0, push 8 matrices with in_repeat=1 → count 1..8, almost_full from count=6, full=1 and in_ready=0 at count 8; a 9th in_valid is not accepted; data then drains in order with no drops.
- Full FIFO, hold in_valid=1, give the final-replay handshake → no push in that cycle; push accepted the next cycle; count 8→7→8.
- Random out_ready backpressure with 4 entries of repeat 2 → out_data stable while stalled; 8 handshakes total; order A,A,B,B,C,C,D,D.
- Assert rst while the head is at out_rep_idx=1 with count=3 → next cycle count=0, out_valid=0, out_rep_idx=0; a fresh push then replays from index 0.
